// File: rtl/countdown_scheduler_if.sv
// Requester-side bundle for the shared countdown scheduler.
// The requesting FSMs drive through master; the scheduler attaches as slave.
interface countdown_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][WIDTH-1:0] load_val;
  logic                          pause;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic [WIDTH-1:0]              count;
  logic [NUM_REQ-1:0]            done;

  modport master (output req, load_val, pause, input grant, busy, count, done);
  modport slave  (input req, load_val, pause, output grant, busy, count, done);
endinterface

// File: rtl/countdown_scheduler.sv
// Round-robin owner of a single down counter: grant, load, count with pause,
// and a one-cycle done pulse back to the owning requester.
module countdown_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_scheduler_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;

  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   owner_nxt;

  // Scan downward so the lowest offset from rr_ptr wins without a break.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign owner_nxt = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_LOAD;
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          count_d = bus.load_val[pick_idx];
          busy_d  = 1'b1;
        end
      end
      S_LOAD, S_COUNT: begin
        // Owner withdrawing its request aborts silently; count is left as-is.
        if (!bus.req[owner_q]) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = owner_nxt;
        end else if (state_q == S_LOAD) begin
          if (count_q == '0) begin
            state_d = S_DONE;
            done_d  = grant_q;
          end else begin
            state_d = S_COUNT;
          end
        end else if (!bus.pause) begin
          if (count_q <= WIDTH'(1)) begin
            state_d = S_DONE;
            done_d  = grant_q;
            count_d = '0;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        count_d  = '0;
        rr_ptr_d = owner_nxt;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.grant = grant_q;
    bus.done  = done_q;
    bus.busy  = busy_q;
    bus.count = count_q;
  end
endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler; observation tuple is
// {grant[3:0], done[3:0], busy, count[3:0]} sampled 1ns after each edge.
module tb_countdown_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  logic [12:0] obs, exp_v;

  countdown_scheduler_if #(.NUM_REQ(4), .WIDTH(4)) bus ();

  countdown_scheduler #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {bus.grant, bus.done, bus.busy, bus.count};
      checks++;
      if (obs !== 13'b0) $display("FAIL reset[%0d]: got %b expected %b", i, obs, 13'b0);
      else passes++;
    end
    rst = 1'b0;
    bus.req = 4'b0000;
  endtask

  task automatic test_single;
    int exp_c[7] = '{5, 5, 4, 3, 2, 1, 0};
    bus.load_val[1] = 4'd5;
    bus.req = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      step();
      obs   = {bus.grant, bus.done, bus.busy, bus.count};
      exp_v = {4'b0010, (i == 6) ? 4'b0010 : 4'b0000, 1'b1, 4'(exp_c[i])};
      checks++;
      if (obs !== exp_v) $display("FAIL single[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
    bus.req = 4'b0000;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== 13'b0) $display("FAIL single_idle: got %b expected %b", obs, 13'b0);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bus.load_val[i] = 4'd2;
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      g = 4'b0001 << (r % 4);
      step();
      obs = {bus.grant, bus.done, bus.busy, bus.count};
      exp_v = {g, 4'b0000, 1'b1, 4'd2};
      checks++;
      if (obs !== exp_v) $display("FAIL rr_grant[%0d]: got %b expected %b", r, obs, exp_v);
      else passes++;
      step();
      step();
      step();
      obs = {bus.grant, bus.done, bus.busy, bus.count};
      exp_v = {g, g, 1'b1, 4'd0};
      checks++;
      if (obs !== exp_v) $display("FAIL rr_done[%0d]: got %b expected %b", r, obs, exp_v);
      else passes++;
      step();
      obs = {bus.grant, bus.done, bus.busy, bus.count};
      checks++;
      if (obs !== 13'b0) $display("FAIL rr_idle[%0d]: got %b expected %b", r, obs, 13'b0);
      else passes++;
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_pause;
    int exp_c[11] = '{6, 6, 5, 4, 4, 4, 4, 3, 2, 1, 0};
    bus.load_val[2] = 4'd6;
    bus.req = 4'b0100;
    for (int i = 0; i < 11; i++) begin
      step();
      obs   = {bus.grant, bus.done, bus.busy, bus.count};
      exp_v = {4'b0100, (i == 10) ? 4'b0100 : 4'b0000, 1'b1, 4'(exp_c[i])};
      checks++;
      if (obs !== exp_v) $display("FAIL pause[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
      bus.pause = (i >= 3 && i <= 5);
    end
    bus.req = 4'b0000;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== 13'b0) $display("FAIL pause_idle: got %b expected %b", obs, 13'b0);
    else passes++;
  endtask

  task automatic test_zero_load;
    bus.load_val[3] = 4'd0;
    bus.req = 4'b1000;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== {4'b1000, 4'b0000, 1'b1, 4'd0}) $display("FAIL zero_load: got %b expected %b", obs, {4'b1000, 4'b0000, 1'b1, 4'd0});
    else passes++;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== {4'b1000, 4'b1000, 1'b1, 4'd0}) $display("FAIL zero_done: got %b expected %b", obs, {4'b1000, 4'b1000, 1'b1, 4'd0});
    else passes++;
    bus.req = 4'b0000;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== 13'b0) $display("FAIL zero_idle: got %b expected %b", obs, 13'b0);
    else passes++;
  endtask

  task automatic test_abort;
    int exp_c[4] = '{5, 5, 4, 3};
    bus.load_val[0] = 4'd5;
    bus.load_val[3] = 4'd2;
    bus.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      obs   = {bus.grant, bus.done, bus.busy, bus.count};
      exp_v = {4'b0001, 4'b0000, 1'b1, 4'(exp_c[i])};
      checks++;
      if (obs !== exp_v) $display("FAIL abort_run[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
    bus.req = 4'b1000;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== {4'b0000, 4'b0000, 1'b0, 4'd3}) $display("FAIL abort_idle: got %b expected %b", obs, {4'b0000, 4'b0000, 1'b0, 4'd3});
    else passes++;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== {4'b1000, 4'b0000, 1'b1, 4'd2}) $display("FAIL abort_next: got %b expected %b", obs, {4'b1000, 4'b0000, 1'b1, 4'd2});
    else passes++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {bus.grant, bus.done, bus.busy, bus.count};
      checks++;
      if (obs !== 13'b0) $display("FAIL midrst[%0d]: got %b expected %b", i, obs, 13'b0);
      else passes++;
    end
    rst = 1'b0;
    bus.req = 4'b0000;
    step();
    obs = {bus.grant, bus.done, bus.busy, bus.count};
    checks++;
    if (obs !== 13'b0) $display("FAIL post_rst: got %b expected %b", obs, 13'b0);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.load_val = '0;
    bus.pause = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_zero_load();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
